// File: rtl/typing_pkg.sv
// Shared types and constants for the typing test controller.
package typing_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ARMED   = 3'd2,
    ST_RUNNING = 3'd3,
    ST_FINISH  = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam logic [7:0] BACKSPACE      = 8'h08;
  localparam int         PROMPT_LEN_DEF = 32;
  localparam int         DIGIT_W        = 4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr takes priority over inc.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // count register with saturation at the top value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r <= {W{1'b0}};
    end else if (clr) begin
      q_r <= {W{1'b0}};
    end else if (inc && (q_r != {W{1'b1}})) begin
      q_r <= q_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/typing_test_ctrl.sv
// Typing test sequencer: drives the stopwatch, scores keystrokes against the
// prompt and freezes the elapsed time once the test ends.
module typing_test_ctrl
  import typing_pkg::*;
#(
  parameter int PROMPT_LEN = PROMPT_LEN_DEF,
  parameter int IDX_W      = 6,
  parameter int CNT_W      = 8,
  parameter int SETTLE     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_begin,
  input  logic               key_valid,
  input  logic [7:0]         key_code,
  input  logic [7:0]         exp_char,
  input  logic               sw_at_end,
  input  logic [3:0]         sw_deci,
  input  logic [3:0]         sw_sec,
  input  logic [3:0]         sw_deca,
  output logic               sw_rst,
  output logic               sw_start,
  output logic [IDX_W-1:0]   char_idx,
  output logic [CNT_W-1:0]   correct_cnt,
  output logic [CNT_W-1:0]   error_cnt,
  output logic [3:0]         final_deci,
  output logic [3:0]         final_sec,
  output logic [3:0]         final_deca,
  output logic               done,
  output logic               timed_out
);

  localparam int                SC_W        = $clog2(SETTLE + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(PROMPT_LEN - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE     = IDX_W'(1);
  localparam logic [SC_W-1:0]   SETTLE_LAST = SC_W'(SETTLE - 1);
  localparam logic [SC_W-1:0]   SETTLE_END  = SC_W'(SETTLE);
  localparam logic [SC_W-1:0]   SC_ONE      = SC_W'(1);

  state_e              state_r, next_s;
  logic [IDX_W-1:0]    idx_r;
  logic [SC_W-1:0]     settle_r;
  logic                sw_rst_r, sw_start_r, done_r, timed_out_r;
  logic                sw_rst_s, sw_start_s, done_s, timed_out_s;
  logic [DIGIT_W-1:0]  fin_deci_r, fin_sec_r, fin_deca_r;
  logic                accept_s, is_bs_s, hit_s, miss_s;
  logic                complete_s, timeout_s, latch_s;

  // keystroke classification; an abort in the same cycle drops the key
  always_comb begin
    accept_s   = ((state_r == ST_ARMED) || (state_r == ST_RUNNING)) && key_valid && !btn_begin;
    is_bs_s    = (key_code == BACKSPACE);
    hit_s      = accept_s && !is_bs_s && (key_code == exp_char);
    miss_s     = accept_s && !is_bs_s && (key_code != exp_char);
    complete_s = (hit_s || miss_s) && (idx_r == LAST_IDX);
    timeout_s  = (state_r == ST_RUNNING) && sw_at_end;
    latch_s    = (state_r == ST_FINISH) && (settle_r == SETTLE_LAST);
  end

  // state register and registered controller outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      sw_rst_r    <= 1'b1;
      sw_start_r  <= 1'b0;
      done_r      <= 1'b0;
      timed_out_r <= 1'b0;
    end else begin
      state_r     <= next_s;
      sw_rst_r    <= sw_rst_s;
      sw_start_r  <= sw_start_s;
      done_r      <= done_s;
      timed_out_r <= timed_out_s;
    end
  end

  // next-state logic; completion outranks timeout
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE:    next_s = btn_begin ? ST_CLEAR : ST_IDLE;
      ST_CLEAR:   next_s = ST_ARMED;
      ST_ARMED: begin
        if (btn_begin)             next_s = ST_CLEAR;
        else if (complete_s)       next_s = ST_FINISH;
        else if (hit_s || miss_s)  next_s = ST_RUNNING;
        else                       next_s = ST_ARMED;
      end
      ST_RUNNING: begin
        if (btn_begin)                    next_s = ST_CLEAR;
        else if (complete_s || timeout_s) next_s = ST_FINISH;
        else                              next_s = ST_RUNNING;
      end
      ST_FINISH:  next_s = (settle_r == SETTLE_END) ? ST_DONE : ST_FINISH;
      ST_DONE:    next_s = btn_begin ? ST_CLEAR : ST_DONE;
      default:    next_s = ST_IDLE;
    endcase
  end

  // outputs are computed from the upcoming state so they register on the transition edge
  always_comb begin
    sw_rst_s   = (next_s == ST_IDLE) || (next_s == ST_CLEAR);
    sw_start_s = (next_s == ST_RUNNING);
    done_s     = (next_s == ST_DONE);
    if (state_r == ST_CLEAR) begin
      timed_out_s = 1'b0;
    end else if ((next_s == ST_FINISH) && (state_r != ST_FINISH)) begin
      timed_out_s = !complete_s;
    end else begin
      timed_out_s = timed_out_r;
    end
  end

  // prompt index: backspace stops at 0, advance holds at the last character
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_r <= {IDX_W{1'b0}};
    end else if (state_r == ST_CLEAR) begin
      idx_r <= {IDX_W{1'b0}};
    end else if (accept_s && is_bs_s && (idx_r != {IDX_W{1'b0}})) begin
      idx_r <= idx_r - IDX_ONE;
    end else if ((hit_s || miss_s) && (idx_r != LAST_IDX)) begin
      idx_r <= idx_r + IDX_ONE;
    end else begin
      idx_r <= idx_r;
    end
  end

  // settle timer and final time capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_r   <= {SC_W{1'b0}};
      fin_deci_r <= 4'd0;
      fin_sec_r  <= 4'd0;
      fin_deca_r <= 4'd0;
    end else begin
      if (state_r != ST_FINISH)          settle_r <= {SC_W{1'b0}};
      else if (settle_r != SETTLE_END)   settle_r <= settle_r + SC_ONE;
      else                               settle_r <= settle_r;
      if (state_r == ST_CLEAR) begin
        fin_deci_r <= 4'd0;
        fin_sec_r  <= 4'd0;
        fin_deca_r <= 4'd0;
      end else if (latch_s) begin
        fin_deci_r <= sw_deci;
        fin_sec_r  <= sw_sec;
        fin_deca_r <= sw_deca;
      end else begin
        fin_deci_r <= fin_deci_r;
        fin_sec_r  <= fin_sec_r;
        fin_deca_r <= fin_deca_r;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_correct (
    .clk (clk), .rst (rst), .inc (hit_s), .clr (state_r == ST_CLEAR), .q (correct_cnt)
  );

  sat_counter #(.W(CNT_W)) u_error (
    .clk (clk), .rst (rst), .inc (miss_s), .clr (state_r == ST_CLEAR), .q (error_cnt)
  );

  assign sw_rst     = sw_rst_r;
  assign sw_start   = sw_start_r;
  assign done       = done_r;
  assign timed_out  = timed_out_r;
  assign char_idx   = idx_r;
  assign final_deci = fin_deci_r;
  assign final_sec  = fin_sec_r;
  assign final_deca = fin_deca_r;

endmodule
